// File: rtl/sdr_16_rx_path.sv
`default_nettype none
// ============================================================================
// Module      : sdr_16_rx_path
// Description : SDR-16 read return path: CAS-latency tracking, beat packing,
//               tagged FWFT return FIFO and read-issue credit.
// Revision    : 1.0
// ============================================================================
module sdr_16_rx_path #(
    parameter int CL    = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_cmd_i,
    input  logic [2:0]    rd_sel_i,
    input  logic [15:0]   dq_pad_i,
    output logic          rd_ok_o,
    output logic [31:0]   rx_dat_o,
    output logic [2:0]    rx_sel_o,
    output logic          rx_valid_o,
    input  logic          rx_re_i,
    output logic [AW:0]   rx_count_o,
    output logic          err_o
);

    localparam int          c_plen  = CL + 2;
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one   = (AW+1)'(1);

    logic [c_plen-1:0] r_pipe_vld;
    logic [2:0]        r_pipe_tag [c_plen];
    logic [15:0]       r_dq_in;
    logic [31:0]       r_word;
    logic [34:0]       r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              r_err;

    logic [AW:0]       w_count;
    logic [AW+1:0]     w_inflight;
    logic [AW+1:0]     w_occupancy;
    logic [34:0]       w_head;
    logic              w_empty;
    logic              w_full;
    logic              w_accept;
    logic              w_cmd_err;
    logic              w_we;
    logic              w_wr_err;
    logic              w_pop;

    // Every valid pipe stage is a read whose word has not reached the FIFO yet.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_plen; i++) begin
            w_inflight = w_inflight + {{(AW+1){1'b0}}, r_pipe_vld[i]};
        end
    end

    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == c_depth);
    assign w_occupancy = {1'b0, w_count} + w_inflight;
    assign rd_ok_o     = (w_occupancy < {1'b0, c_depth});

    assign w_accept  = rd_cmd_i & rd_ok_o & ~r_pipe_vld[0];
    assign w_cmd_err = rd_cmd_i & ~w_accept;
    assign w_we      = r_pipe_vld[c_plen-1] & ~w_full;
    assign w_wr_err  = r_pipe_vld[c_plen-1] & w_full;
    assign w_pop     = rx_re_i & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[c_plen-2:0], w_accept};
            if (w_we) begin
                r_wptr <= r_wptr + c_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_one;
            end
            if (w_cmd_err | w_wr_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data path carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        r_pipe_tag[0] <= rd_sel_i;
        for (int i = 1; i < c_plen; i++) begin
            r_pipe_tag[i] <= r_pipe_tag[i-1];
        end
        r_dq_in <= dq_pad_i;
        if (r_pipe_vld[CL]) begin
            r_word <= {r_dq_in, dq_pad_i};
        end
        if (w_we) begin
            r_mem[r_wptr[AW-1:0]] <= {r_pipe_tag[c_plen-1], r_word};
        end
    end

    assign w_head     = r_mem[r_rptr[AW-1:0]];
    assign rx_dat_o   = w_head[31:0];
    assign rx_sel_o   = w_head[34:32];
    assign rx_valid_o = ~w_empty;
    assign rx_count_o = w_count;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdr_16_rx_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdr_16_rx_path
// Description : Self-checking bench for sdr_16_rx_path (CL=2 and CL=3).
// Revision    : 1.0
// ============================================================================
module tb_sdr_16_rx_path;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CL    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rd_cmd, rx_re;
    logic [2:0]  rd_sel;
    logic [15:0] dq, dq3;

    logic        rd_ok2, rx_valid2, err2;
    logic [31:0] rx_dat2;
    logic [2:0]  rx_sel2;
    logic [AW:0] cnt2;
    logic        rd_ok3, rx_valid3, err3;
    logic [31:0] rx_dat3;
    logic [2:0]  rx_sel3;
    logic [AW:0] cnt3;

    sdr_16_rx_path #(.CL(2), .DEPTH(DEPTH), .AW(AW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rd_cmd_i(rd_cmd), .rd_sel_i(rd_sel),
        .dq_pad_i(dq), .rd_ok_o(rd_ok2), .rx_dat_o(rx_dat2), .rx_sel_o(rx_sel2),
        .rx_valid_o(rx_valid2), .rx_re_i(rx_re), .rx_count_o(cnt2), .err_o(err2)
    );

    sdr_16_rx_path #(.CL(3), .DEPTH(DEPTH), .AW(AW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_cmd_i(rd_cmd), .rd_sel_i(rd_sel),
        .dq_pad_i(dq3), .rd_ok_o(rd_ok3), .rx_dat_o(rx_dat3), .rx_sel_o(rx_sel3),
        .rx_valid_o(rx_valid3), .rx_re_i(rx_re), .rx_count_o(cnt3), .err_o(err3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the CL=2 instance: a queue of outstanding reads with
    // their due cycle and a queue of buffered tagged words.
    typedef struct packed {
        int         wcyc;
        logic [2:0] tag;
    } pend_t;

    pend_t       m_pend [$];
    logic [34:0] m_fifo [$];
    logic [15:0] m_dq [0:2047];
    int          m_cyc  = 0;
    int          m_last = -10;
    logic        m_err  = 1'b0;
    bit          m_on   = 1'b0;

    always @(posedge clk) begin
        int    pre_fifo;
        int    pre_pend;
        bit    ok;
        pend_t p;
        m_dq[m_cyc % 2048] = dq;
        if (!rst_n) begin
            m_fifo.delete();
            m_pend.delete();
            m_err  = 1'b0;
            m_last = -10;
            m_on   = 1'b1;
        end else begin
            pre_fifo = m_fifo.size();
            pre_pend = m_pend.size();
            ok = (pre_fifo + pre_pend) < DEPTH;
            if (rx_re && pre_fifo > 0) void'(m_fifo.pop_front());
            if (pre_pend > 0 && m_pend[0].wcyc == m_cyc) begin
                if (pre_fifo >= DEPTH) m_err = 1'b1;
                else m_fifo.push_back({m_pend[0].tag, m_dq[(m_cyc-2) % 2048], m_dq[(m_cyc-1) % 2048]});
                void'(m_pend.pop_front());
            end
            if (rd_cmd) begin
                if (ok && m_last != m_cyc - 1) begin
                    p.wcyc = m_cyc + CL + 2;
                    p.tag  = rd_sel;
                    m_pend.push_back(p);
                    m_last = m_cyc;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_cyc++;
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model_valid", {63'd0, rx_valid2}, {63'd0, m_fifo.size() != 0});
            check("model_count", {60'd0, cnt2}, 64'(m_fifo.size()));
            check("model_rd_ok", {63'd0, rd_ok2}, {63'd0, (m_fifo.size() + m_pend.size()) < DEPTH});
            check("model_err", {63'd0, err2}, {63'd0, m_err});
            if (m_fifo.size() != 0) begin
                check("model_dat", {32'd0, rx_dat2}, {32'd0, m_fifo[0][31:0]});
                check("model_sel", {61'd0, rx_sel2}, {61'd0, m_fifo[0][34:32]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int last;
        rst_n = 1'b0; rd_cmd = 1'b0; rd_sel = 3'd0; rx_re = 1'b0; dq = '0; dq3 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_valid", {63'd0, rx_valid2}, 64'd0);
        check("rst_count", {60'd0, cnt2}, 64'd0);
        check("rst_rd_ok", {63'd0, rd_ok2}, 64'd1);
        check("rst_err", {63'd0, err2}, 64'd0);
        check("rst_rd_ok_cl3", {63'd0, rd_ok3}, 64'd1);

        // Single read on both latencies, plus pops while empty.
        rd_cmd = 1'b1; rd_sel = 3'd5;
        tick();
        rd_cmd = 1'b0; rd_sel = 3'd0;
        tick();
        dq = 16'hDEAD;
        tick();
        dq = 16'hBEEF; dq3 = 16'hDEAD;
        tick();
        dq = 16'h0000; dq3 = 16'hBEEF;
        check("single_valid_c4", {63'd0, rx_valid2}, 64'd0);
        tick();
        dq3 = 16'h0000;
        check("single_valid_c5", {63'd0, rx_valid2}, 64'd1);
        check("single_dat", {32'd0, rx_dat2}, 64'hDEADBEEF);
        check("single_sel", {61'd0, rx_sel2}, 64'd5);
        check("single_count", {60'd0, cnt2}, 64'd1);
        check("cl3_valid_c5", {63'd0, rx_valid3}, 64'd0);
        rx_re = 1'b1;
        tick();
        check("single_pop_count", {60'd0, cnt2}, 64'd0);
        check("cl3_valid_c6", {63'd0, rx_valid3}, 64'd1);
        check("cl3_dat", {32'd0, rx_dat3}, 64'hDEADBEEF);
        check("cl3_sel", {61'd0, rx_sel3}, 64'd5);
        tick();
        rx_re = 1'b0;
        check("empty_pop_err", {63'd0, err2}, 64'd0);
        check("empty_pop_count", {60'd0, cnt2}, 64'd0);
        check("cl3_empty_pop_err", {63'd0, err3}, 64'd0);
        check("cl3_pop_count", {60'd0, cnt3}, 64'd0);

        // Streaming fill, every 2nd cycle whenever credit allows.
        n_acc = 0;
        last  = -10;
        for (int c = 0; c < 40; c++) begin
            dq = 16'hA500 ^ 16'(c * 37);
            if (rd_ok2 && (c - last) >= 2) begin
                rd_cmd = 1'b1;
                rd_sel = 3'(n_acc);
                n_acc++;
                last = c;
            end else begin
                rd_cmd = 1'b0;
            end
            tick();
        end
        rd_cmd = 1'b0;
        check("stream_accepted", 64'(n_acc), 64'd8);
        check("stream_count", {60'd0, cnt2}, 64'd8);
        check("stream_rd_ok", {63'd0, rd_ok2}, 64'd0);
        check("stream_err", {63'd0, err2}, 64'd0);
        check("stream_head_tag", {61'd0, rx_sel2}, 64'd0);

        // Credit release and refill.
        rx_re = 1'b1;
        check("credit_rd_ok_before", {63'd0, rd_ok2}, 64'd0);
        tick();
        rx_re = 1'b0;
        check("credit_count", {60'd0, cnt2}, 64'd7);
        check("credit_rd_ok", {63'd0, rd_ok2}, 64'd1);
        rd_cmd = 1'b1; rd_sel = 3'd0; dq = 16'h1234;
        tick();
        rd_cmd = 1'b0;
        check("refill_rd_ok", {63'd0, rd_ok2}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            dq = 16'h5A00 + 16'(i);
            tick();
        end
        check("refill_count", {60'd0, cnt2}, 64'd8);
        check("refill_err", {63'd0, err2}, 64'd0);

        // Read with no credit is refused.
        rd_cmd = 1'b1; rd_sel = 3'd3;
        tick();
        rd_cmd = 1'b0;
        check("nocredit_err", {63'd0, err2}, 64'd1);
        repeat (6) tick();
        check("nocredit_count", {60'd0, cnt2}, 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("drain_tag", {61'd0, rx_sel2}, {61'd0, 3'(i + 1)});
            rx_re = 1'b1;
            tick();
        end
        rx_re = 1'b0;
        check("drain_count", {60'd0, cnt2}, 64'd0);

        // Back-to-back commands.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_err", {63'd0, err2}, 64'd0);
        rd_cmd = 1'b1; rd_sel = 3'd2;
        tick();
        rd_cmd = 1'b1; rd_sel = 3'd6;
        tick();
        rd_cmd = 1'b0;
        check("b2b_err", {63'd0, err2}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            dq = 16'hC0DE + 16'(i);
            tick();
        end
        check("b2b_count", {60'd0, cnt2}, 64'd1);
        check("b2b_sel", {61'd0, rx_sel2}, 64'd2);
        rx_re = 1'b1;
        tick();
        rx_re = 1'b0;

        // Reset with reads in flight and words buffered.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            rd_cmd = (c % 2 == 0);
            rd_sel = 3'(c / 2 + 1);
            dq     = 16'h7700 + 16'(c);
            tick();
        end
        rd_cmd = 1'b0;
        check("midrst_count_before", {60'd0, cnt2}, 64'd3);
        check("midrst_rd_ok_before", {63'd0, rd_ok2}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", {63'd0, rx_valid2}, 64'd0);
        check("midrst_count", {60'd0, cnt2}, 64'd0);
        check("midrst_rd_ok", {63'd0, rd_ok2}, 64'd1);
        check("midrst_err", {63'd0, err2}, 64'd0);
        repeat (8) tick();
        check("midrst_no_late_count", {60'd0, cnt2}, 64'd0);
        check("midrst_no_late_valid", {63'd0, rx_valid2}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
